// File: rtl/vram_draw_ctrl.sv
// Sprite-draw (DXYN, XOR read-modify-write) and CLS sequencer for the vram port.
// Build option: define SPRITE_WRAP_EN to wrap off-screen sprite pixels instead of clipping.
module vram_draw_ctrl #(
  parameter int SCREEN_W = 64,
  parameter int SCREEN_H = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        cmd_clear,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] i_addr,
  input  logic [1:0]  plane,
  output logic        ready,
  output logic        done,
  output logic        collision,
  output logic [11:0] ram_addr,
  input  logic [7:0]  ram_dout,
  output logic [6:0]  vram_hpos,
  output logic [5:0]  vram_vpos,
  input  logic [1:0]  vram_pixeli,
  output logic [1:0]  vram_pixelo,
  output logic        vram_we
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FETCH_WAIT,
    PIX_RD,
    PIX_WR,
    PIX_SKIP,
    CLEAR,
    DONE
  } state_t;

  localparam logic [6:0] XMASK = 7'(SCREEN_W - 1);
  localparam logic [5:0] YMASK = 6'(SCREEN_H - 1);
  localparam logic [7:0] XLIM  = 8'(SCREEN_W);
  localparam logic [6:0] YLIM  = 7'(SCREEN_H);

  state_t      state_q, state_d;
  logic [6:0]  x0_q;
  logic [5:0]  y0_q;
  logic        wide_q;
  logic [3:0]  rmax_q;
  logic [1:0]  plane_q;
  logic [11:0] addr_q;
  logic [15:0] bits_q, bits_d;
  logic [3:0]  c_q;
  logic [3:0]  r_q;
  logic        k_q;
  logic [6:0]  hc_q;
  logic [5:0]  vc_q;
  logic        coll_q;
  logic [3:0]  cmax;
  logic        row_end;
  logic        last_row;
  logic        clr_end;
  logic [6:0]  pix_h;
  logic [5:0]  pix_v;

  // Pick the state for a sprite pixel: drawn pixels need RMW, others skip.
  function automatic state_t pix_sel(
    input logic       b,
    input logic [6:0] xo,
    input logic [5:0] yo,
    input logic [3:0] col,
    input logic [3:0] row
  );
    logic [7:0] px;
    logic [6:0] py;
    logic       on;
    px = {1'b0, xo} + {4'd0, col};
    py = {1'b0, yo} + {3'd0, row};
    on = (px < XLIM) && (py < YLIM);
`ifdef SPRITE_WRAP_EN
    on = 1'b1;
`endif
    return (b && on) ? PIX_RD : PIX_SKIP;
  endfunction

  assign cmax     = wide_q ? 4'd15 : 4'd7;
  assign row_end  = (c_q == cmax);
  assign last_row = (r_q == rmax_q);
  assign clr_end  = (hc_q == XMASK) && (vc_q == YMASK);
  assign pix_h    = (x0_q + {3'd0, c_q}) & XMASK;
  assign pix_v    = (y0_q + {2'd0, r_q}) & YMASK;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = cmd_clear ? CLEAR : FETCH;
      end
      FETCH: state_d = FETCH_WAIT;
      FETCH_WAIT: begin
        bits_d = k_q ? {bits_q[15:8], ram_dout}
                     : {ram_dout, 8'h00};
        if (wide_q && !k_q) state_d = FETCH;
        else state_d = pix_sel(bits_d[15], x0_q, y0_q,
                               4'd0, r_q);
      end
      PIX_RD: state_d = PIX_WR;
      PIX_WR, PIX_SKIP: begin
        if (row_end) state_d = last_row ? DONE : FETCH;
        else state_d = pix_sel(bits_q[14], x0_q, y0_q,
                               c_q + 4'd1, r_q);
      end
      CLEAR: begin
        if (clr_end) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0_q    <= '0;
      y0_q    <= '0;
      wide_q  <= 1'b0;
      rmax_q  <= '0;
      plane_q <= '0;
      addr_q  <= '0;
      bits_q  <= '0;
      c_q     <= '0;
      r_q     <= '0;
      k_q     <= 1'b0;
      hc_q    <= '0;
      vc_q    <= '0;
      coll_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            x0_q    <= x & XMASK;
            y0_q    <= y & YMASK;
            wide_q  <= (n == 4'd0);
            rmax_q  <= n - 4'd1;
            plane_q <= plane;
            addr_q  <= i_addr;
            bits_q  <= '0;
            c_q     <= '0;
            r_q     <= '0;
            k_q     <= 1'b0;
            hc_q    <= '0;
            vc_q    <= '0;
            coll_q  <= 1'b0;
          end
        end
        FETCH_WAIT: begin
          bits_q <= bits_d;
          addr_q <= addr_q + 12'd1;
          k_q    <= wide_q & ~k_q;
        end
        PIX_WR, PIX_SKIP: begin
          if (state_q == PIX_WR && |(vram_pixeli & plane_q))
            coll_q <= 1'b1;
          bits_q <= {bits_q[14:0], 1'b0};
          if (row_end) begin
            c_q <= '0;
            r_q <= r_q + 4'd1;
          end else begin
            c_q <= c_q + 4'd1;
          end
        end
        CLEAR: begin
          if (hc_q == XMASK) begin
            hc_q <= '0;
            vc_q <= vc_q + 6'd1;
          end else begin
            hc_q <= hc_q + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ready       = (state_q == IDLE);
    done        = (state_q == DONE);
    collision   = coll_q;
    ram_addr    = '0;
    vram_hpos   = '0;
    vram_vpos   = '0;
    vram_pixelo = '0;
    vram_we     = 1'b0;
    unique case (1'b1)
      (state_q == FETCH): ram_addr = addr_q;
      (state_q == PIX_RD): begin
        vram_hpos = pix_h;
        vram_vpos = pix_v;
      end
      (state_q == PIX_WR): begin
        vram_hpos   = pix_h;
        vram_vpos   = pix_v;
        vram_pixelo = vram_pixeli ^ plane_q;
        vram_we     = 1'b1;
      end
      (state_q == CLEAR): begin
        vram_hpos = hc_q;
        vram_vpos = vc_q;
        vram_we   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
